calc_sequencer: RTL and testbench

Keypad-side control sequencer for the four-function 8-bit calculator. It turns decoded keypad key strobes into decimal operands and drives the arithmetic unit's control interface: `IN`, `operation`, `ldA`, `ldB`, `Start`, `Loadresult` and `Clear`. It waits for completion on `Halt` (multiply/divide) or a fixed delay (add/subtract), then commands the result load. It sits between the keypad scanner/decoder and the arithmetic unit.

---
 rtl/calc_pkg.sv | 48 ++++
 rtl/calc_sequencer_decimal_entry.sv | 41 ++++
 rtl/calc_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator keypad sequencer.
// Key codes 0-9 are digits; the op keys map onto the one-hot operation bus.
package calc_pkg;

    typedef enum logic [3:0] {
        StEnterA,
        StSetupA,
        StLoadA,
        StEnterB,
        StSetupB,
        StLoadB,
        StStart,
        StWait,
        StLoadR,
        StShow
    } state_e;

    localparam logic [3:0] KeyAdd = 4'd10;
    localparam logic [3:0] KeySub = 4'd11;
    localparam logic [3:0] KeyMul = 4'd12;
    localparam logic [3:0] KeyDiv = 4'd13;
    localparam logic [3:0] KeyEq  = 4'd14;
    localparam logic [3:0] KeyClr = 4'd15;

    localparam logic [3:0] OpNone = 4'b0000;
    localparam logic [3:0] OpAdd  = 4'b1000;
    localparam logic [3:0] OpSub  = 4'b0100;
    localparam logic [3:0] OpMul  = 4'b0010;
    localparam logic [3:0] OpDiv  = 4'b0001;

    function automatic logic [3:0] key_to_op(input logic [3:0] key);
        logic [3:0] op;
        case (key)
            KeyAdd:  op = OpAdd;
            KeySub:  op = OpSub;
            KeyMul:  op = OpMul;
            KeyDiv:  op = OpDiv;
            default: op = OpNone;
        endcase
        return op;
    endfunction

    // ENTER_B is excluded: it accepts keys, so it cannot count as busy.
    function automatic logic is_busy(input state_e s);
        return s inside {StSetupA, StLoadA, StSetupB, StLoadB, StStart, StWait, StLoadR};
    endfunction

endpackage

// File: rtl/calc_sequencer_decimal_entry.sv
// Decimal operand accumulator: value*10 + digit, refusing any digit that would exceed 255.
module decimal_entry (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic       digit_valid_i,
    input  logic [3:0] digit_i,
    output logic [7:0] value_o,
    output logic       overflow_o
);

    logic [7:0]  value_q, value_d;
    logic [11:0] next_val;

    // overflow_o reflects the digit on digit_i whether or not it is applied,
    // so the caller can decide without a combinational loop.
    always_comb begin
        next_val   = {4'd0, value_q} * 12'd10 + {8'd0, digit_i};
        overflow_o = next_val > 12'd255;
        value_d    = value_q;
        if (clr_i) begin
            value_d = 8'd0;
        end else if (load_i) begin
            value_d = {4'd0, digit_i};
        end else if (digit_valid_i && !overflow_o) begin
            value_d = next_val[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= 8'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-side control sequencer: builds decimal operands from key strobes and
// drives the arithmetic unit's load/start/result handshake.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned ADDSUB_WAIT = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       Halt,
    output logic [7:0] IN,
    output logic [3:0] operation,
    output logic       ldA,
    output logic       ldB,
    output logic       Start,
    output logic       Loadresult,
    output logic       Clear,
    output logic [7:0] entry,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CntMax = (TIMEOUT > ADDSUB_WAIT) ? TIMEOUT : ADDSUB_WAIT;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] AddsubLast  = CntW'(ADDSUB_WAIT - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [7:0]      in_q, in_d;
    logic [3:0]      op_q, op_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            clear_q, clear_d;
    logic            lda_q, ldb_q, start_q, loadr_q, busy_q;

    logic            de_clr, de_load, de_digit, de_overflow;
    logic [7:0]      entry_val;
    logic            key_digit, key_op;

    decimal_entry u_entry (
        .clk_i         (Clock),
        .rst_i         (reset),
        .clr_i         (de_clr),
        .load_i        (de_load),
        .digit_valid_i (de_digit),
        .digit_i       (key_code),
        .value_o       (entry_val),
        .overflow_o    (de_overflow)
    );

    always_comb begin
        state_d   = state_q;
        in_d      = in_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        clear_d   = 1'b0;
        de_clr    = 1'b0;
        de_load   = 1'b0;
        de_digit  = 1'b0;
        key_digit = key_code <= 4'd9;
        key_op    = key_code inside {[KeyAdd:KeyDiv]};

        if (key_valid && key_code == KeyClr) begin
            state_d = StEnterA;
            in_d    = 8'd0;
            op_d    = OpNone;
            cnt_d   = '0;
            err_d   = 1'b0;
            clear_d = 1'b1;
            de_clr  = 1'b1;
        end else begin
            unique case (state_q)
                StEnterA, StEnterB: begin
                    if (key_valid) begin
                        if (key_digit) begin
                            de_digit = 1'b1;
                            err_d    = de_overflow;
                        end else if (key_op) begin
                            err_d = 1'b0;
                            op_d  = key_to_op(key_code);
                            if (state_q == StEnterA) begin
                                in_d    = entry_val;
                                state_d = StSetupA;
                            end
                        end else if (key_code == KeyEq && state_q == StEnterB) begin
                            if (op_q == OpDiv && entry_val == 8'd0) begin
                                err_d   = 1'b1;
                                de_clr  = 1'b1;
                                state_d = StEnterA;
                            end else begin
                                err_d   = 1'b0;
                                in_d    = entry_val;
                                state_d = StSetupB;
                            end
                        end
                    end
                end
                StSetupA: state_d = StLoadA;
                StLoadA: begin
                    de_clr  = 1'b1;
                    state_d = StEnterB;
                end
                StSetupB: state_d = StLoadB;
                StLoadB:  state_d = StStart;
                StStart: begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
                StWait: begin
                    if (op_q == OpAdd || op_q == OpSub) begin
                        if (cnt_q == AddsubLast) begin
                            state_d = StLoadR;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (Halt && cnt_q != '0) begin
                        // The first WAIT cycle ignores Halt, which may still be
                        // left over from the previous operation.
                        state_d = StLoadR;
                    end else if (cnt_q == TimeoutLast) begin
                        err_d   = 1'b1;
                        clear_d = 1'b1;
                        op_d    = OpNone;
                        de_clr  = 1'b1;
                        state_d = StEnterA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StLoadR: state_d = StShow;
                StShow: begin
                    if (key_valid && key_digit) begin
                        err_d   = 1'b0;
                        de_load = 1'b1;
                        state_d = StEnterA;
                    end else if (key_valid && key_op) begin
                        // Chain on the held result: A already holds it, go straight to B.
                        err_d   = 1'b0;
                        op_d    = key_to_op(key_code);
                        de_clr  = 1'b1;
                        state_d = StEnterB;
                    end
                end
                default: state_d = StEnterA;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= StEnterA;
            in_q    <= 8'd0;
            op_q    <= OpNone;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            clear_q <= 1'b0;
            lda_q   <= 1'b0;
            ldb_q   <= 1'b0;
            start_q <= 1'b0;
            loadr_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            clear_q <= clear_d;
            lda_q   <= state_d == StLoadA;
            ldb_q   <= state_d == StLoadB;
            start_q <= state_d == StStart;
            loadr_q <= state_d == StLoadR;
            busy_q  <= is_busy(state_d);
        end
    end

    assign IN         = in_q;
    assign operation  = op_q;
    assign ldA        = lda_q;
    assign ldB        = ldb_q;
    assign Start      = start_q;
    assign Loadresult = loadr_q;
    assign Clear      = clear_q;
    assign entry      = entry_val;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus queues the expected command strobes,
// a negedge monitor pops and checks each strobe the DUT emits.
module tb_calc_sequencer;

    typedef struct {
        int         kind;
        int         cycle;
        logic [7:0] in_v;
        logic [3:0] op;
        bit         chk_in;
    } exp_t;

    localparam int KLdA = 0, KLdB = 1, KStart = 2, KLoadR = 3, KClear = 4;

    logic       Clock, reset, key_valid, Halt;
    logic [3:0] key_code;
    logic [7:0] IN, entry;
    logic [3:0] operation;
    logic       ldA, ldB, Start, Loadresult, Clear, busy, err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    logic [4:0] mon_strb;
    int         mon_kind;
    exp_t       mon_e;

    calc_sequencer dut (
        .Clock      (Clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .Halt       (Halt),
        .IN         (IN),
        .operation  (operation),
        .ldA        (ldA),
        .ldB        (ldB),
        .Start      (Start),
        .Loadresult (Loadresult),
        .Clear      (Clear),
        .entry      (entry),
        .busy       (busy),
        .err        (err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            KLdA:    return "ldA";
            KLdB:    return "ldB";
            KStart:  return "Start";
            KLoadR:  return "Loadresult";
            default: return "Clear";
        endcase
    endfunction

    // Cycle numbering: cycle c is the cycle that follows clock edge c-1.
    always @(negedge Clock) begin
        if (mon_en) begin
            mon_strb = {ldA, ldB, Start, Loadresult, Clear};
            if (mon_strb != 5'd0) begin
                n_checks++;
                if ($countones(mon_strb) != 1) begin
                    n_fail++;
                    $display("FAIL strobe_onehot: cycle %0d strobes=%b required one-hot", cyc + 1,
                             mon_strb);
                end else begin
                    case (mon_strb)
                        5'b10000: mon_kind = KLdA;
                        5'b01000: mon_kind = KLdB;
                        5'b00100: mon_kind = KStart;
                        5'b00010: mon_kind = KLoadR;
                        default:  mon_kind = KClear;
                    endcase
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_%s: cycle %0d IN=%0d op=%b, none required",
                                 kname(mon_kind), cyc + 1, IN, operation);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.kind != mon_kind || mon_e.cycle != cyc + 1 ||
                            mon_e.op != operation || (mon_e.chk_in && mon_e.in_v != IN)) begin
                            n_fail++;
                            $display("FAIL strobe_%s: got %s at cycle %0d IN=%0d op=%b, required %s at cycle %0d IN=%0d op=%b",
                                     kname(mon_e.kind), kname(mon_kind), cyc + 1, IN, operation,
                                     kname(mon_e.kind), mon_e.cycle, mon_e.in_v, mon_e.op);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic expect_strobe(input int kind, input int cycle, input logic [7:0] in_v,
                                 input logic [3:0] op, input bit chk_in);
        exp_t e;
        e.kind   = kind;
        e.cycle  = cycle;
        e.in_v   = in_v;
        e.op     = op;
        e.chk_in = chk_in;
        sb.push_back(e);
    endtask

    // Called #1 after an edge; the key is sampled at the next edge, returned in t.
    task automatic press(input logic [3:0] c, output int t);
        key_code  = c;
        key_valid = 1'b1;
        t         = cyc + 1;
        @(posedge Clock);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic to_cycle(input int c);
        while (cyc + 1 < c) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_IN"}, int'(IN), 0);
        chk({tag, "_op"}, int'(operation), 0);
        chk({tag, "_entry"}, int'(entry), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int t, d;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        Halt      = 1'b0;
        idle(3);
        chk("reset_strobes", int'({ldA, ldB, Start, Loadresult, Clear}), 0);
        check_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(1);

        // 12 + 3
        press(4'd1, d);
        press(4'd2, d);
        chk("add_entryA", int'(entry), 12);
        press(4'd10, t);
        expect_strobe(KLdA, t + 2, 8'd12, 4'b1000, 1'b1);
        idle(3);
        press(4'd3, d);
        chk("add_entryB", int'(entry), 3);
        press(4'd14, t);
        expect_strobe(KLdB, t + 2, 8'd3, 4'b1000, 1'b1);
        expect_strobe(KStart, t + 3, 8'd3, 4'b1000, 1'b1);
        expect_strobe(KLoadR, t + 6, 8'd3, 4'b1000, 1'b1);
        to_cycle(t + 4);
        chk("add_busy_wait", int'(busy), 1);
        to_cycle(t + 7);
        chk("add_busy_show", int'(busy), 0);

        // 2,5,5,7: the 7 overflows
        press(4'd2, d);
        press(4'd5, d);
        press(4'd5, d);
        chk("ovf_entry255", int'(entry), 255);
        chk("ovf_err_before", int'(err), 0);
        press(4'd7, d);
        chk("ovf_entry_held", int'(entry), 255);
        chk("ovf_err", int'(err), 1);
        press(4'd15, t);
        expect_strobe(KClear, t + 1, 8'd0, 4'b0000, 1'b1);
        check_zero("clr1");

        // 15 * 17 with Halt 10 cycles after Start
        press(4'd1, d);
        press(4'd5, d);
        press(4'd12, t);
        expect_strobe(KLdA, t + 2, 8'd15, 4'b0010, 1'b1);
        idle(3);
        press(4'd1, d);
        press(4'd7, d);
        press(4'd14, t);
        expect_strobe(KLdB, t + 2, 8'd17, 4'b0010, 1'b1);
        expect_strobe(KStart, t + 3, 8'd17, 4'b0010, 1'b1);
        expect_strobe(KLoadR, t + 14, 8'd17, 4'b0010, 1'b1);
        to_cycle(t + 13);
        chk("mul_op_wait", int'(operation), 4'b0010);
        chk("mul_busy_wait", int'(busy), 1);
        Halt = 1'b1;
        to_cycle(t + 14);
        Halt = 1'b0;
        to_cycle(t + 15);
        chk("mul_busy_show", int'(busy), 0);
        chk("mul_err", int'(err), 0);

        // 9 / 0
        press(4'd9, d);
        press(4'd13, t);
        expect_strobe(KLdA, t + 2, 8'd9, 4'b0001, 1'b1);
        idle(3);
        press(4'd0, d);
        press(4'd14, d);
        chk("div0_err", int'(err), 1);
        chk("div0_entry", int'(entry), 0);
        chk("div0_busy", int'(busy), 0);
        idle(4);
        press(4'd4, d);
        chk("div0_enterA_entry", int'(entry), 4);
        chk("div0_err_cleared", int'(err), 0);

        // 4 * 2 with Halt never raised
        press(4'd12, t);
        expect_strobe(KLdA, t + 2, 8'd4, 4'b0010, 1'b1);
        idle(3);
        press(4'd2, d);
        press(4'd14, t);
        expect_strobe(KLdB, t + 2, 8'd2, 4'b0010, 1'b1);
        expect_strobe(KStart, t + 3, 8'd2, 4'b0010, 1'b1);
        expect_strobe(KClear, t + 68, 8'd0, 4'b0000, 1'b0);
        to_cycle(t + 67);
        chk("tmo_busy_last_wait", int'(busy), 1);
        chk("tmo_err_before", int'(err), 0);
        to_cycle(t + 68);
        chk("tmo_err", int'(err), 1);
        chk("tmo_op", int'(operation), 0);
        chk("tmo_busy", int'(busy), 0);
        press(4'd5, d);
        chk("tmo_digit_entry", int'(entry), 5);
        chk("tmo_err_cleared", int'(err), 0);

        // 5 + 6, clear during WAIT
        press(4'd10, t);
        expect_strobe(KLdA, t + 2, 8'd5, 4'b1000, 1'b1);
        idle(3);
        press(4'd6, d);
        press(4'd14, t);
        expect_strobe(KLdB, t + 2, 8'd6, 4'b1000, 1'b1);
        expect_strobe(KStart, t + 3, 8'd6, 4'b1000, 1'b1);
        to_cycle(t + 4);
        press(4'd15, t);
        expect_strobe(KClear, t + 1, 8'd0, 4'b0000, 1'b1);
        check_zero("clr_wait");
        idle(6);

        // 8 - 3, reset during LOAD_B
        press(4'd8, d);
        press(4'd11, t);
        expect_strobe(KLdA, t + 2, 8'd8, 4'b0100, 1'b1);
        idle(3);
        press(4'd3, d);
        press(4'd14, t);
        expect_strobe(KLdB, t + 2, 8'd3, 4'b0100, 1'b1);
        to_cycle(t + 2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_zero("rst_loadb");
        idle(8);

        chk("scoreboard_drained", sb.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
